// File: rtl/seq_divider_16bit_if.sv
// Handshake and operand/result bundle for the sequential 16-bit divider.
interface seq_divider_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_16bit.sv
// Restoring shift-subtract divider, one quotient bit per cycle, with ALU-style saturation.
// Optional SEQDIV_EARLY_EXIT_EN: skip the iteration when the divisor is zero or exceeds the dividend.
module seq_divider_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_16bit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             sgn;
  logic             q_neg;
  logic             dvs_zero;
  logic             ovf_case;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   rem_sh;
  logic             trial_ge;
  logic             early;

  // Operand magnitudes at accept time and the per-iteration trial subtract.
  always_comb begin
    dvd_mag_in = (bus.signed_op && bus.dividend[WIDTH-1]) ? WIDTH'(-bus.dividend) : bus.dividend;
    dvs_mag_in = (bus.signed_op && bus.divisor[WIDTH-1])  ? WIDTH'(-bus.divisor)  : bus.divisor;
    rem_sh     = {rem, quo[WIDTH-1]};
    trial_ge   = (rem_sh >= {1'b0, dvs_mag});
`ifdef SEQDIV_EARLY_EXIT_EN
    early      = (dvs_mag_in == '0) || (dvd_mag_in < dvs_mag_in);
`else
    early      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rem             <= '0;
      quo             <= '0;
      dvs_mag         <= '0;
      dvd_raw         <= '0;
      sgn             <= 1'b0;
      q_neg           <= 1'b0;
      dvs_zero        <= 1'b0;
      ovf_case        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvs_mag  <= dvs_mag_in;
            dvd_raw  <= bus.dividend;
            sgn      <= bus.signed_op;
            q_neg    <= bus.signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            dvs_zero <= (bus.divisor == '0);
            ovf_case <= bus.signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == ALL_ONES);
            cnt      <= CW'(WIDTH);
            bus.busy <= 1'b1;
            // On early exit the remainder already holds |dividend| and the quotient is zero.
            if (early) begin
              rem   <= dvd_mag_in;
              quo   <= '0;
              state <= FIX;
            end else begin
              rem   <= '0;
              quo   <= dvd_mag_in;
              state <= DIV;
            end
          end
        end

        DIV: begin
          rem <= trial_ge ? WIDTH'(rem_sh - {1'b0, dvs_mag}) : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], trial_ge};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dvs_zero) begin
            bus.quotient    <= !sgn ? ALL_ONES : (dvd_raw[WIDTH-1] ? MIN_NEG : MAX_POS);
            bus.remainder   <= dvd_raw;
            bus.div_by_zero <= 1'b1;
            bus.overflow    <= 1'b0;
          end else if (ovf_case) begin
            bus.quotient    <= MAX_POS;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b1;
          end else begin
            // Truncation toward zero: remainder follows the dividend's sign.
            bus.quotient    <= q_neg ? WIDTH'(-quo) : quo;
            bus.remainder   <= (sgn && dvd_raw[WIDTH-1]) ? WIDTH'(-rem) : rem;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
